// File: rtl/control_sequencer.sv
// Sequential half of the CPU control unit: state register, instruction and status registers,
// per-state strobes and a watchdog. Optional retired-instruction counter: CONTROL_SEQUENCER_ICOUNT_EN.
module control_sequencer #(
  parameter int WATCHDOG_CYCLES = 16,
  parameter int COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [7:0]         next_state_in,
  input  logic [15:0]        mem_rdata,
  input  logic [3:0]         alu_flags,
  output logic [7:0]         state,
  output logic [15:0]        instr,
  output logic [3:0]         status_reg,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               flags_we,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [7:0] {
    S_IDLE  = 8'h00,
    S_DECOD = 8'h01,
    S_SUB2  = 8'h08,
    S_ADD2  = 8'h0B,
    S_XOR2  = 8'h0E,
    S_FETCH = 8'h0F,
    S_CPU1  = 8'h27
  } state_e;

  localparam int                WD_W    = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(WATCHDOG_CYCLES);

  // State is kept as a raw byte so illegal codes from the next-state logic are held verbatim.
  logic [7:0]      state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [3:0]      status_q, status_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            fault_q, fault_d;

  assign ir_load  = (state_q == S_FETCH);
  assign pc_inc   = (state_q == S_FETCH);
  assign flags_we = (state_q == S_ADD2) || (state_q == S_SUB2) ||
                    (state_q == S_XOR2) || (state_q == S_CPU1);

  // Next-state, register loads and watchdog.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    status_d = status_q;
    wd_cnt_d = wd_cnt_q;
    fault_d  = 1'b0;
    if (run) begin
      state_d = next_state_in;
      if (ir_load) begin
        instr_d = mem_rdata;
      end else begin
        instr_d = instr_q;
      end
      if (flags_we) begin
        status_d = alu_flags;
      end else begin
        status_d = status_q;
      end
      if (state_q == S_IDLE) begin
        wd_cnt_d = '0;
      end else if (wd_cnt_q == WD_LAST) begin
        // Expiry forces idle; instr/status loads above still take effect.
        state_d  = S_IDLE;
        wd_cnt_d = '0;
        fault_d  = 1'b1;
      end else if (wd_cnt_q < WD_MAX) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
    end else begin
      if (state_q == S_IDLE) begin
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
    end
  end

  // Core register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 16'h0000;
      status_q <= 4'h0;
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      status_q <= status_d;
      wd_cnt_q <= wd_cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign state      = state_q;
  assign instr      = instr_q;
  assign status_reg = status_q;
  assign fault      = fault_q;

`ifdef CONTROL_SEQUENCER_ICOUNT_EN
  logic [COUNT_W-1:0] icount_q, icount_d;
  logic               retire;

  assign retire = run && (state_q != S_IDLE) && (state_d == S_IDLE) && !fault_d;

  // Retired-instruction counter; watchdog recoveries are excluded.
  always_comb begin
    icount_d = icount_q;
    if (retire) begin
      icount_d = icount_q + COUNT_W'(1);
    end else begin
      icount_d = icount_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign instr_count = icount_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected post-edge values,
// a monitor pops and compares one entry after each rising edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  next_state_in = 8'h00;
  logic [15:0] mem_rdata = 16'h0000;
  logic [3:0]  alu_flags = 4'h0;
  logic [7:0]  state;
  logic [15:0] instr;
  logic [3:0]  status_reg;
  logic        ir_load, pc_inc, flags_we, fault;
  logic [15:0] instr_count;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .next_state_in(next_state_in),
    .mem_rdata(mem_rdata), .alu_flags(alu_flags), .state(state), .instr(instr),
    .status_reg(status_reg), .ir_load(ir_load), .pc_inc(pc_inc), .flags_we(flags_we),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  st;
    logic [15:0] ins;
    logic [3:0]  sr;
    logic        flt;
    logic [15:0] ic;
    logic [4:0]  mask; // 0 state+strobes, 1 instr, 2 status, 3 fault, 4 count
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  logic [15:0] exp_icnt = 16'h0000;

  localparam logic [4:0] ALL = 5'b11111;

  function automatic logic [15:0] ic_model(input logic [15:0] v);
`ifdef CONTROL_SEQUENCER_ICOUNT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rs, input logic rn, input logic [7:0] nsi,
                      input logic [15:0] rd, input logic [3:0] af, input logic [7:0] es,
                      input logic [15:0] ei, input logic [3:0] esr, input logic ef,
                      input logic [4:0] m);
    exp_t e;
    @(negedge clk);
    reset = rs; run = rn; next_state_in = nsi; mem_rdata = rd; alu_flags = af;
    e.st = es; e.ins = ei; e.sr = esr; e.flt = ef; e.ic = ic_model(exp_icnt); e.mask = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare against the oldest expectation just after each active edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.mask[0]) begin
          chk(nm, "state", {8'h00, state}, {8'h00, e.st});
          chk(nm, "ir_load", {15'h0, ir_load}, {15'h0, (e.st == 8'h0F)});
          chk(nm, "pc_inc", {15'h0, pc_inc}, {15'h0, (e.st == 8'h0F)});
          chk(nm, "flags_we", {15'h0, flags_we},
              {15'h0, (e.st == 8'h0B || e.st == 8'h08 || e.st == 8'h0E || e.st == 8'h27)});
        end
        if (e.mask[1]) chk(nm, "instr", instr, e.ins);
        if (e.mask[2]) chk(nm, "status", {12'h0, status_reg}, {12'h0, e.sr});
        if (e.mask[3]) chk(nm, "fault", {15'h0, fault}, {15'h0, e.flt});
        if (e.mask[4]) chk(nm, "icount", instr_count, e.ic);
      end
    end
  end

  initial begin
    // Reset from unknown state.
    step("rst0",   1'b1, 1'b0, 8'h00, 16'h0000, 4'h0, 8'h00, 16'h0000, 4'h0, 1'b0, ALL);
    // Fetch of ADD 2123 and flag writes.
    step("f_0F",   1'b0, 1'b1, 8'h0F, 16'hDEAD, 4'h0, 8'h0F, 16'h0000, 4'h0, 1'b0, ALL);
    step("f_01",   1'b0, 1'b1, 8'h01, 16'h2123, 4'h0, 8'h01, 16'h2123, 4'h0, 1'b0, ALL);
    step("f_09",   1'b0, 1'b1, 8'h09, 16'hBEEF, 4'hF, 8'h09, 16'h2123, 4'h0, 1'b0, ALL);
    step("f_0A",   1'b0, 1'b1, 8'h0A, 16'hBEEF, 4'hF, 8'h0A, 16'h2123, 4'h0, 1'b0, ALL);
    for (int i = 0; i < 5; i++)
      step("stall", 1'b0, 1'b0, 8'h0B, 16'hBEEF, 4'hF, 8'h0A, 16'h2123, 4'h0, 1'b0, ALL);
    step("f_0B",   1'b0, 1'b1, 8'h0B, 16'hBEEF, 4'h0, 8'h0B, 16'h2123, 4'h0, 1'b0, ALL);
    step("flg_we", 1'b0, 1'b1, 8'h0B, 16'hBEEF, 4'b0010, 8'h0B, 16'h2123, 4'b0010, 1'b0, ALL);
    step("flg_st", 1'b0, 1'b0, 8'h00, 16'hBEEF, 4'b1111, 8'h0B, 16'h2123, 4'b0010, 1'b0, ALL);
    exp_icnt = 16'd1;
    step("add_rt", 1'b0, 1'b1, 8'h00, 16'hBEEF, 4'b1000, 8'h00, 16'h2123, 4'b1000, 1'b0, ALL);
    // Flag-writing states 08, 0E, 27.
    step("sub2",   1'b0, 1'b1, 8'h08, 16'h0000, 4'b1111, 8'h08, 16'h2123, 4'b1000, 1'b0, ALL);
    step("xor2",   1'b0, 1'b1, 8'h0E, 16'h0000, 4'b0001, 8'h0E, 16'h2123, 4'b0001, 1'b0, ALL);
    step("cpu1",   1'b0, 1'b1, 8'h27, 16'h0000, 4'b0100, 8'h27, 16'h2123, 4'b0100, 1'b0, ALL);
    exp_icnt = 16'd2;
    step("cpu_rt", 1'b0, 1'b1, 8'h00, 16'h0000, 4'b1001, 8'h00, 16'h2123, 4'b1001, 1'b0, ALL);
    step("idle_h", 1'b0, 1'b1, 8'h00, 16'h0000, 4'b1111, 8'h00, 16'h2123, 4'b1001, 1'b0, ALL);
    // Three MOV instructions.
    for (int k = 1; k <= 3; k++) begin
      step("mov_0F", 1'b0, 1'b1, 8'h0F, 16'h0000, 4'h0, 8'h0F, (k == 1) ? 16'h2123 : 16'h3000 + 16'(k - 1), 4'b1001, 1'b0, ALL);
      step("mov_01", 1'b0, 1'b1, 8'h01, 16'h3000 + 16'(k), 4'h0, 8'h01, 16'h3000 + 16'(k), 4'b1001, 1'b0, ALL);
      step("mov_03", 1'b0, 1'b1, 8'h03, 16'hFFFF, 4'h0, 8'h03, 16'h3000 + 16'(k), 4'b1001, 1'b0, ALL);
      exp_icnt = 16'd2 + 16'(k);
      step("mov_rt", 1'b0, 1'b1, 8'h00, 16'hFFFF, 4'h0, 8'h00, 16'h3000 + 16'(k), 4'b1001, 1'b0, ALL);
    end
    // Watchdog on illegal state 55: nonzero edges 0F, 01, then 55 until the 16th forces idle.
    step("wd_0F",  1'b0, 1'b1, 8'h0F, 16'h0000, 4'h0, 8'h0F, 16'h3003, 4'b1001, 1'b0, ALL);
    step("wd_01",  1'b0, 1'b1, 8'h01, 16'h4444, 4'h0, 8'h01, 16'h4444, 4'b1001, 1'b0, ALL);
    for (int i = 0; i < 14; i++)
      step("wd_55", 1'b0, 1'b1, 8'h55, 16'h9999, 4'h0, 8'h55, 16'h4444, 4'b1001, 1'b0, ALL);
    step("wd_exp", 1'b0, 1'b1, 8'h55, 16'h9999, 4'h0, 8'h00, 16'h4444, 4'b1001, 1'b1, ALL);
    step("wd_pls", 1'b0, 1'b1, 8'h00, 16'h9999, 4'h0, 8'h00, 16'h4444, 4'b1001, 1'b0, ALL);
    // Watchdog expiry while in fetch: instr still loads on the expiring edge.
    step("wf_in",  1'b0, 1'b1, 8'h0F, 16'h1001, 4'h0, 8'h0F, 16'h4444, 4'b1001, 1'b0, ALL);
    for (int k = 2; k <= 16; k++)
      step("wf_0F", 1'b0, 1'b1, 8'h0F, 16'h1000 + 16'(k), 4'h0, 8'h0F, 16'h1000 + 16'(k), 4'b1001, 1'b0, ALL);
    step("wf_exp", 1'b0, 1'b1, 8'h0F, 16'hABCD, 4'h0, 8'h00, 16'hABCD, 4'b1001, 1'b1, ALL);
    step("wf_pls", 1'b0, 1'b1, 8'h00, 16'h0000, 4'h0, 8'h00, 16'hABCD, 4'b1001, 1'b0, ALL);
    // Reset mid-ADD.
    step("ra_0F",  1'b0, 1'b1, 8'h0F, 16'h0000, 4'h0, 8'h0F, 16'hABCD, 4'b1001, 1'b0, ALL);
    step("ra_01",  1'b0, 1'b1, 8'h01, 16'h2123, 4'h0, 8'h01, 16'h2123, 4'b1001, 1'b0, ALL);
    step("ra_09",  1'b0, 1'b1, 8'h09, 16'h0000, 4'h0, 8'h09, 16'h2123, 4'b1001, 1'b0, ALL);
    exp_icnt = 16'd0;
    step("ra_rst", 1'b1, 1'b1, 8'h0A, 16'h5555, 4'hF, 8'h00, 16'h0000, 4'h0, 1'b0, ALL);
    step("ra_aft", 1'b0, 1'b0, 8'h0A, 16'h5555, 4'hF, 8'h00, 16'h0000, 4'h0, 1'b0, ALL);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
